// File: rtl/mcu_block_scheduler.sv
// ============================================================================
// mcu_block_scheduler
// ----------------------------------------------------------------------------
// Sequences the entropy decoder block by block through a JPEG-style frame.
// It walks the MCUs of the frame and the blocks inside each MCU. It only
// issues a block when the downstream coefficient accumulator can take one.
// It can also stop between MCUs so that a restart marker is consumed.
//
// Optional feature macro: MCU_SCHED_RESTART_EN
//   defined   -> restart-interval handling (RESTART state, marker handshake)
//   undefined -> no restart handling; rst_marker_req tied low, the interval
//                and the ack input are ignored
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   start                   one-cycle frame start, honoured only when idle
//   abort                   synchronous abort, wins over every other input
//   cfg_mode                0/3 gray (1 blk), 1 4:4:4 (3 blk), 2 4:2:0 (6 blk)
//   cfg_mcu_count           MCUs in the frame
//   cfg_restart_interval    MCUs between restart markers, 0 = none
//   dec_start               one-cycle pulse: decode one block now
//   comp_id, tbl_sel        component of issued block and its table select
//   dec_block_done          decoder finished the current block
//   acc_block_valid/ready   accumulator output handshake (monitored only)
//   dc_pred_reset           one-cycle pulse clearing the DC predictors
//   rst_marker_req/ack      restart-marker consumption handshake
//   busy, frame_done        frame in progress / frame complete pulse
//   mcu_index, block_in_mcu current position inside the frame
// ============================================================================
module mcu_block_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  cfg_mode,
    input  logic [15:0] cfg_mcu_count,
    input  logic [15:0] cfg_restart_interval,
    output logic        dec_start,
    output logic [1:0]  comp_id,
    output logic        tbl_sel,
    input  logic        dec_block_done,
    input  logic        acc_block_valid,
    input  logic        acc_block_ready,
    output logic        dc_pred_reset,
    output logic        rst_marker_req,
    input  logic        rst_marker_ack,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] mcu_index,
    output logic [2:0]  block_in_mcu
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DEC,
        WAIT_ACC,
`ifdef MCU_SCHED_RESTART_EN
        RESTART,
`endif
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mode_q;
    logic [15:0] mcu_count_q;
    logic [1:0]  comp_q;
    logic [1:0]  comp_next;
    logic [2:0]  blocks_per_mcu;
    logic        acc_free;
    logic        last_blk;
    logic        last_mcu;
    logic        restart_due;
    logic        start_acc;
    logic        blk_done;
    logic        dc_req;

`ifdef MCU_SCHED_RESTART_EN
    logic [15:0] interval_q;
    logic [15:0] rst_cnt_q;

    // rst_cnt_q counts MCUs completed since the last marker (or frame start),
    // so a marker is due when the MCU that is finishing now fills the interval.
    assign restart_due    = (interval_q != 16'd0) && ((rst_cnt_q + 16'd1) == interval_q);
    assign rst_marker_req = (state_q == RESTART);
`else
    logic unused_restart;

    assign unused_restart = ^{cfg_restart_interval, rst_marker_ack};
    assign restart_due    = 1'b0;
    assign rst_marker_req = 1'b0;
`endif

    assign acc_free = !acc_block_valid || acc_block_ready;
    assign busy     = (state_q != IDLE);
    assign last_blk = (block_in_mcu == (blocks_per_mcu - 3'd1));
    assign last_mcu = (mcu_index == (mcu_count_q - 16'd1));

    // The component mux is transparent during the issue cycle, so comp_id is
    // valid together with dec_start. After that it holds the registered copy
    // until the next block is issued.
    assign comp_id = dec_start ? comp_next : comp_q;
    assign tbl_sel = (comp_id != 2'd0);

    // Block geometry of the latched mode: blocks per MCU and the component
    // that owns the current block.
    always_comb begin
        blocks_per_mcu = 3'd1;
        comp_next      = 2'd0;
        case (mode_q)
            2'd1: begin
                blocks_per_mcu = 3'd3;
                comp_next      = block_in_mcu[1:0];
            end
            2'd2: begin
                blocks_per_mcu = 3'd6;
                if (block_in_mcu == 3'd4) begin
                    comp_next = 2'd1;
                end else if (block_in_mcu == 3'd5) begin
                    comp_next = 2'd2;
                end
            end
            default: begin
                blocks_per_mcu = 3'd1;
                comp_next      = 2'd0;
            end
        endcase
    end

    // Next-state and pulse generation. ISSUE rechecks the accumulator because
    // it may have raised valid while the FSM was moving out of WAIT_ACC. In
    // that case the FSM drops back to WAIT_ACC instead of issuing, so
    // dec_start can never fire into a stalled accumulator.
    always_comb begin
        state_d    = state_q;
        dec_start  = 1'b0;
        frame_done = 1'b0;
        start_acc  = 1'b0;
        blk_done   = 1'b0;
        dc_req     = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        start_acc = 1'b1;
                        dc_req    = 1'b1;
                        state_d   = (cfg_mcu_count == 16'd0) ? DONE : WAIT_ACC;
                    end
                end
                WAIT_ACC: begin
                    if (acc_free) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (acc_free) begin
                        dec_start = 1'b1;
                        state_d   = WAIT_DEC;
                    end else begin
                        state_d = WAIT_ACC;
                    end
                end
                WAIT_DEC: begin
                    if (dec_block_done) begin
                        blk_done = 1'b1;
                        if (last_blk && last_mcu) begin
                            state_d = DONE;
`ifdef MCU_SCHED_RESTART_EN
                        end else if (last_blk && restart_due) begin
                            state_d = RESTART;
`endif
                        end else begin
                            state_d = WAIT_ACC;
                        end
                    end
                end
`ifdef MCU_SCHED_RESTART_EN
                RESTART: begin
                    if (rst_marker_ack) begin
                        dc_req  = 1'b1;
                        state_d = WAIT_ACC;
                    end
                end
`endif
                DONE: begin
                    if (acc_free) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, latched configuration and frame position. An abort clears the
    // position counters but keeps the configuration, which is reloaded on
    // the next accepted start anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mode_q        <= 2'd0;
            mcu_count_q   <= 16'd0;
            mcu_index     <= 16'd0;
            block_in_mcu  <= 3'd0;
            comp_q        <= 2'd0;
            dc_pred_reset <= 1'b0;
`ifdef MCU_SCHED_RESTART_EN
            interval_q    <= 16'd0;
            rst_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            dc_pred_reset <= dc_req;
            if (abort) begin
                mcu_index    <= 16'd0;
                block_in_mcu <= 3'd0;
                comp_q       <= 2'd0;
`ifdef MCU_SCHED_RESTART_EN
                rst_cnt_q    <= 16'd0;
`endif
            end else if (start_acc) begin
                mode_q       <= cfg_mode;
                mcu_count_q  <= cfg_mcu_count;
                mcu_index    <= 16'd0;
                block_in_mcu <= 3'd0;
`ifdef MCU_SCHED_RESTART_EN
                interval_q   <= cfg_restart_interval;
                rst_cnt_q    <= 16'd0;
`endif
            end else if (blk_done) begin
                if (last_blk) begin
                    block_in_mcu <= 3'd0;
                    mcu_index    <= mcu_index + 16'd1;
`ifdef MCU_SCHED_RESTART_EN
                    rst_cnt_q    <= restart_due ? 16'd0 : (rst_cnt_q + 16'd1);
`endif
                end else begin
                    block_in_mcu <= block_in_mcu + 3'd1;
                end
            end else if (dec_start) begin
                comp_q <= comp_next;
            end
        end
    end

endmodule

// File: tb/tb_mcu_block_scheduler.sv
`timescale 1ns/1ps
// ============================================================================
// tb_mcu_block_scheduler
// ----------------------------------------------------------------------------
// Directed bench for mcu_block_scheduler. A single process drives every
// input. Within that process a small decoder model answers each dec_start,
// an accumulator model can stall after each block, and a marker model acks
// restart requests. Expected component ids are queued when a frame is
// started and popped whenever the DUT issues a block.
// ============================================================================
module tb_mcu_block_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_mcu_count = 16'd0;
    logic [15:0] cfg_restart_interval = 16'd0;
    logic        dec_start;
    logic [1:0]  comp_id;
    logic        tbl_sel;
    logic        dec_block_done;
    logic        model_done = 1'b0;
    logic        stray_done = 1'b0;
    logic        acc_block_valid = 1'b0;
    logic        acc_block_ready = 1'b1;
    logic        dc_pred_reset;
    logic        rst_marker_req;
    logic        rst_marker_ack = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [15:0] mcu_index;
    logic [2:0]  block_in_mcu;

    int n_checks = 0;
    int n_errors = 0;
    int n_dec = 0;
    int n_fd = 0;
    int n_dc = 0;
    int n_req_rise = 0;
    int hold_left = 0;
    int dec0, fd0, dc0, rq0;
    bit dec_pending = 0;
    bit ack_pending = 0;
    bit acc_trigger = 0;
    bit hold_mode = 0;
    bit force_stall = 0;
    bit auto_dec = 1;
    bit req_prev = 0;
    logic [1:0] exp_q[$];

    assign dec_block_done = model_done | stray_done;

    always #5 clk = ~clk;

    mcu_block_scheduler dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .abort                (abort),
        .cfg_mode             (cfg_mode),
        .cfg_mcu_count        (cfg_mcu_count),
        .cfg_restart_interval (cfg_restart_interval),
        .dec_start            (dec_start),
        .comp_id              (comp_id),
        .tbl_sel              (tbl_sel),
        .dec_block_done       (dec_block_done),
        .acc_block_valid      (acc_block_valid),
        .acc_block_ready      (acc_block_ready),
        .dc_pred_reset        (dc_pred_reset),
        .rst_marker_req       (rst_marker_req),
        .rst_marker_ack       (rst_marker_ack),
        .busy                 (busy),
        .frame_done           (frame_done),
        .mcu_index            (mcu_index),
        .block_in_mcu         (block_in_mcu)
    );

    // Component that owns block blk of an MCU in the given mode.
    function automatic logic [1:0] expComp(input logic [1:0] mode, input int blk);
        if (mode == 2'd2) return (blk < 4) ? 2'd0 : ((blk == 4) ? 2'd1 : 2'd2);
        if (mode == 2'd1) return blk[1:0];
        return 2'd0;
    endfunction

    function automatic int blocksPerMcu(input logic [1:0] mode);
        if (mode == 2'd2) return 6;
        if (mode == 2'd1) return 3;
        return 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples the DUT at the falling edge and updates the models.
    task automatic sampleOutputs();
        logic [1:0] e;
        if (dec_start) begin
            n_dec++;
            checkOutput("dec_start_acc_free", !(acc_block_valid && !acc_block_ready), 1);
            checkOutput("dec_start_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("comp_id", comp_id, e);
                checkOutput("tbl_sel", tbl_sel, e != 2'd0);
            end
            if (auto_dec) dec_pending = 1;
        end
        if (model_done && hold_mode) acc_trigger = 1;
        if (rst_marker_req && !rst_marker_ack) ack_pending = 1;
        if (rst_marker_req && !req_prev) n_req_rise++;
        req_prev = rst_marker_req;
        if (dc_pred_reset) n_dc++;
        if (frame_done) n_fd++;
    endtask

    // One clock: drive model-controlled inputs just after the rising edge,
    // then sample at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        model_done     = dec_pending;
        dec_pending    = 0;
        rst_marker_ack = ack_pending;
        ack_pending    = 0;
        if (acc_trigger) begin
            hold_left   = 11;
            acc_trigger = 0;
        end
        if (force_stall) begin
            acc_block_valid = 1'b1;
            acc_block_ready = 1'b0;
        end else if (hold_left > 1) begin
            acc_block_valid = 1'b1;
            acc_block_ready = 1'b0;
            hold_left--;
        end else if (hold_left == 1) begin
            acc_block_valid = 1'b1;
            acc_block_ready = 1'b1;
            hold_left = 0;
        end else begin
            acc_block_valid = 1'b0;
            acc_block_ready = 1'b1;
        end
        @(negedge clk);
        sampleOutputs();
    endtask

    // Drives a start pulse; the expected components are queued only when the
    // start is expected to be accepted.
    task automatic applyStimulus(input logic [1:0] mode, input int count, input int interval, input bit accepted);
        cfg_mode             = mode;
        cfg_mcu_count        = count[15:0];
        cfg_restart_interval = interval[15:0];
        if (accepted) begin
            for (int m = 0; m < count; m++)
                for (int b = 0; b < blocksPerMcu(mode); b++)
                    exp_q.push_back(expComp(mode, b));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic runUntilFrameDone(input string tag, input int base, input int budget);
        int k = 0;
        while (n_fd == base && k < budget) begin
            tick();
            k++;
        end
        checkOutput({tag, "_frame_done_in_time"}, n_fd != base, 1);
    endtask

    task automatic runUntilDec(input string tag, input int target, input int budget);
        int k = 0;
        while (n_dec < target && k < budget) begin
            tick();
            k++;
        end
        checkOutput({tag, "_dec_in_time"}, n_dec >= target, 1);
    endtask

    task automatic snapshot();
        dec0 = n_dec;
        fd0  = n_fd;
        dc0  = n_dc;
        rq0  = n_req_rise;
    endtask

    initial begin
        $display("[TB] mcu_block_scheduler bench starting");

        // Reset state
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dec_start", dec_start, 0);
        checkOutput("rst_comp_id", comp_id, 0);
        checkOutput("rst_dc_pred_reset", dc_pred_reset, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_mcu_index", mcu_index, 0);
        checkOutput("rst_block_in_mcu", block_in_mcu, 0);
        rst_n = 1'b1;
        tick();

        // 4:2:0, one MCU, accumulator always ready
        snapshot();
        applyStimulus(2'd2, 1, 0, 1);
        checkOutput("f420_dc_pulse_after_start", dc_pred_reset, 1);
        checkOutput("f420_busy", busy, 1);
        runUntilFrameDone("f420", fd0, 200);
        checkOutput("f420_dec_count", n_dec - dec0, 6);
        checkOutput("f420_mcu_index", mcu_index, 1);
        checkOutput("f420_block_in_mcu", block_in_mcu, 0);
        tick();
        checkOutput("f420_idle", busy, 0);
        checkOutput("f420_frame_done_count", n_fd - fd0, 1);
        checkOutput("f420_dc_count", n_dc - dc0, 1);

        // 4:4:4, two MCUs, accumulator stalls 10 cycles after every block
        snapshot();
        hold_mode = 1;
        applyStimulus(2'd1, 2, 0, 1);
        runUntilFrameDone("f444", fd0, 1000);
        hold_mode = 0;
        checkOutput("f444_dec_count", n_dec - dec0, 6);
        checkOutput("f444_mcu_index", mcu_index, 2);
        checkOutput("f444_queue_empty", exp_q.size(), 0);
        tick();
        tick();

        // Mode 3 behaves as gray
        snapshot();
        applyStimulus(2'd3, 2, 0, 1);
        runUntilFrameDone("mode3", fd0, 200);
        checkOutput("mode3_dec_count", n_dec - dec0, 2);
        tick();

        // Empty frame
        snapshot();
        applyStimulus(2'd0, 0, 0, 1);
        runUntilFrameDone("empty", fd0, 50);
        tick();
        checkOutput("empty_dec_count", n_dec - dec0, 0);
        checkOutput("empty_dc_count", n_dc - dc0, 1);
        checkOutput("empty_idle", busy, 0);

        // Gray, four MCUs, restart interval 2
        snapshot();
        applyStimulus(2'd0, 4, 2, 1);
        runUntilFrameDone("rstint", fd0, 400);
        tick();
        checkOutput("rstint_dec_count", n_dec - dec0, 4);
`ifdef MCU_SCHED_RESTART_EN
        checkOutput("rstint_marker_requests", n_req_rise - rq0, 1);
        checkOutput("rstint_dc_count", n_dc - dc0, 2);
`else
        checkOutput("rstint_marker_requests", n_req_rise - rq0, 0);
        checkOutput("rstint_dc_count", n_dc - dc0, 1);
`endif
        checkOutput("rstint_req_low", rst_marker_req, 0);

        // Start while busy and a stray block-done in WAIT_ACC are ignored
        snapshot();
        force_stall = 1;
        applyStimulus(2'd1, 1, 0, 1);
        tick();
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        checkOutput("stray_block_in_mcu", block_in_mcu, 0);
        checkOutput("stray_mcu_index", mcu_index, 0);
        applyStimulus(2'd0, 0, 0, 0);
        tick();
        checkOutput("busy_start_dc_count", n_dc - dc0, 1);
        checkOutput("busy_start_dec_count", n_dec - dec0, 0);
        force_stall = 0;
        runUntilFrameDone("stray", fd0, 200);
        checkOutput("stray_dec_count", n_dec - dec0, 3);
        tick();

        // Abort while waiting on the fourth block
        snapshot();
        applyStimulus(2'd2, 2, 0, 1);
        runUntilDec("abort", dec0 + 3, 200);
        auto_dec = 0;
        runUntilDec("abort4", dec0 + 4, 200);
        tick();
        tick();
        checkOutput("abort_pre_block_in_mcu", block_in_mcu, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        auto_dec = 1;
        exp_q.delete();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_block_in_mcu", block_in_mcu, 0);
        checkOutput("abort_mcu_index", mcu_index, 0);
        checkOutput("abort_comp_id", comp_id, 0);
        checkOutput("abort_req", rst_marker_req, 0);
        tick();
        tick();
        checkOutput("abort_no_frame_done", n_fd - fd0, 0);

        // Asynchronous reset in the middle of a frame
        snapshot();
        applyStimulus(2'd2, 1, 0, 1);
        runUntilDec("midrst", dec0 + 2, 200);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_comp_id", comp_id, 0);
        checkOutput("midrst_tbl_sel", tbl_sel, 0);
        checkOutput("midrst_dec_start", dec_start, 0);
        checkOutput("midrst_dc_pred_reset", dc_pred_reset, 0);
        checkOutput("midrst_mcu_index", mcu_index, 0);
        checkOutput("midrst_block_in_mcu", block_in_mcu, 0);
        tick();
        tick();
        rst_n = 1'b1;
        dec_pending = 0;
        exp_q.delete();
        tick();
        tick();
        checkOutput("midrst_no_frame_done", n_fd - fd0, 0);
        checkOutput("midrst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mcu_block_scheduler.md
MCU_BLOCK_SCHEDULER -- requirements
Module: mcu_block_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE.
REQ-004 abort  in  1  synchronous frame abort; overrides every other input.
REQ-005 cfg_mode  in  2  0=gray (1 blk/MCU), 1=4:4:4 (3), 2=4:2:0 (6), 3=treated as gray; sampled only on accepted start.
REQ-006 cfg_mcu_count  in  16  MCUs per frame; sampled on accepted start.
REQ-007 cfg_restart_interval  in  16  MCUs between restart markers; 0=none; sampled on accepted start.
REQ-008 dec_start  out  1  one-cycle pulse: entropy decoder decodes one block.
REQ-009 comp_id  out  2  component of issued block; held stable from dec_start until next dec_start.
REQ-010 tbl_sel  out  1  Huffman/quant table select: 0 if comp_id==0, else 1.
REQ-011 dec_block_done  in  1  pulse from decoder: current block finished (same pulse feeding the coefficient accumulator).
REQ-012 acc_block_valid, acc_block_ready  in  1 each  monitored accumulator output handshake.
REQ-013 dc_pred_reset  out  1  one-cycle pulse clearing decoder DC predictors.
REQ-014 rst_marker_req  out  1  level; request to consume RSTn marker; rst_marker_ack  in  1  pulse completing it.
REQ-015 busy  out  1; frame_done  out  1 pulse; mcu_index  out  16; block_in_mcu  out  3.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT_DEC, WAIT_ACC, RESTART, DONE.
REQ-017 IDLE + start: latch cfg, mcu_index=0, block_in_mcu=0, dc_pred_reset pulse next cycle; go DONE if cfg_mcu_count==0, else WAIT_ACC.
REQ-018 acc_free = !acc_block_valid || acc_block_ready; WAIT_ACC -> ISSUE when acc_free.
REQ-019 ISSUE: dec_start=1 for exactly that cycle, comp_id/tbl_sel valid same cycle; -> WAIT_DEC.
REQ-020 4:2:0 mapping: blocks 0-3 comp 0, block 4 comp 1, block 5 comp 2; 4:4:4: block n -> comp n; gray: comp 0.
REQ-021 WAIT_DEC + dec_block_done: block_in_mcu increments; at last block of MCU wraps to 0 and mcu_index increments (16-bit).
REQ-022 Same event: if last block of last MCU -> DONE; else if MCU just completed, interval!=0, completed-MCU count mod interval==0 -> RESTART; else -> WAIT_ACC.
REQ-023 RESTART: rst_marker_req=1 until rst_marker_ack; on ack, dc_pred_reset pulse next cycle, -> WAIT_ACC; no restart after final MCU.
REQ-024 DONE: wait acc_free, then frame_done pulse one cycle, -> IDLE.
REQ-025 dec_start SHALL never assert while acc_block_valid && !acc_block_ready.
REQ-026 busy=1 in every state except IDLE.
REQ-027 abort in any state: next cycle IDLE, rst_marker_req=0, no frame_done, counters cleared.
REQ-028 dec_block_done outside WAIT_DEC and rst_marker_ack outside RESTART SHALL be ignored.

Reset
REQ-029 rst_n low: IDLE; all outputs 0; latched cfg and counters 0; takes effect immediately, mid-frame included.

Configuration
REQ-030 Macro MCU_SCHED_RESTART_EN defined: REQ-007/014/023 active.
REQ-031 Undefined: RESTART state and interval counter absent; cfg_restart_interval ignored; rst_marker_req tied 0; rst_marker_ack ignored.

Verification
REQ-032 mode=2, count=1, ready always 1 -> 6 dec_start, comp_id 0,0,0,0,1,2; tbl_sel 0,0,0,0,1,1; one frame_done.
REQ-033 mode=1, count=2, ready held 0 for 10 cycles after each done -> no dec_start while acc_block_valid&&!ready; 6 blocks total.
REQ-034 MACRO on, mode=0, count=4, interval=2 -> one rst_marker_req after MCU 2, dec_pred_reset pulses at start and after ack; none after MCU 4.
REQ-035 count=0 -> dc_pred_reset, frame_done, zero dec_start.
REQ-036 abort in WAIT_DEC after 3 blocks, then rst_n low mid-frame -> IDLE, busy=0, no frame_done, outputs 0.
REQ-037 start while busy, stray dec_block_done in WAIT_ACC -> no effect on counters or state.
